// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into 32-bit words tagged with a sequential PC, queued in an output FIFO.
// Latency: an accepted set is at the FIFO head (e_o_valid=1) the cycle after the accept edge when the FIFO was empty.
// Backpressure: e_o_ready = !full from the count register only; a full FIFO refuses new sets even while popping.
// Optional feature macro: ENCODER_RANGE_CHECK_EN (also rejects immediates that do not fit their encoded field).

`ifndef OPCODE_OP
`define OPCODE_OP      7'b0110011
`endif
`ifndef OPCODE_OP_IMM
`define OPCODE_OP_IMM  7'b0010011
`endif
`ifndef OPCODE_LOAD
`define OPCODE_LOAD    7'b0000011
`endif
`ifndef OPCODE_STORE
`define OPCODE_STORE   7'b0100011
`endif
`ifndef OPCODE_BRANCH
`define OPCODE_BRANCH  7'b1100011
`endif
`ifndef OPCODE_JAL
`define OPCODE_JAL     7'b1101111
`endif
`ifndef OPCODE_JALR
`define OPCODE_JALR    7'b1100111
`endif
`ifndef OPCODE_LUI
`define OPCODE_LUI     7'b0110111
`endif
`ifndef OPCODE_AUIPC
`define OPCODE_AUIPC   7'b0010111
`endif
`ifndef OPCODE_SYSTEM
`define OPCODE_SYSTEM  7'b1110011
`endif
`ifndef OPCODE_FENCE
`define OPCODE_FENCE   7'b0001111
`endif

module instr_encoder #(
  parameter int                  DEPTH    = 4,
  parameter int                  PC_WIDTH = 32,
  parameter int                  AWIDTH   = 5,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                e_clk,
  input  logic                e_rst,
  input  logic                e_i_valid,
  output logic                e_o_ready,
  input  logic [3:0]          e_i_op,
  input  logic [2:0]          e_i_funct3,
  input  logic                e_i_alt,
  input  logic [AWIDTH-1:0]   e_i_rs1,
  input  logic [AWIDTH-1:0]   e_i_rs2,
  input  logic [AWIDTH-1:0]   e_i_rd,
  input  logic [31:0]         e_i_imm,
  input  logic                e_i_flush,
  output logic                e_o_valid,
  input  logic                e_i_ready,
  output logic [31:0]         e_o_instr,
  output logic [PC_WIDTH-1:0] e_o_pc,
  output logic                e_o_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] OP_RTYPE  = 4'd0;
  localparam logic [3:0] OP_ITYPE  = 4'd1;
  localparam logic [3:0] OP_LOAD   = 4'd2;
  localparam logic [3:0] OP_STORE  = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_JAL    = 4'd5;
  localparam logic [3:0] OP_JALR   = 4'd6;
  localparam logic [3:0] OP_LUI    = 4'd7;
  localparam logic [3:0] OP_AUIPC  = 4'd8;
  localparam logic [3:0] OP_SYSTEM = 4'd9;
  localparam logic [3:0] OP_FENCE  = 4'd10;

  // Register fields are 5 bits in RV32I; wider address ports keep only the low bits.
  logic [4:0]  rs1_f, rs2_f, rd_f;
  logic        is_shift;
  logic [11:0] shamt_f;
  logic [31:0] word;
  logic        legal_op;
  logic        range_ok;
  logic        accept, push, reject, pop;

  logic [31:0]         mem_instr [DEPTH];
  logic [PC_WIDTH-1:0] mem_pc    [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic [PC_WIDTH-1:0] pc_tag;
  logic                err;

  assign rs1_f    = e_i_rs1[4:0];
  assign rs2_f    = e_i_rs2[4:0];
  assign rd_f     = e_i_rd[4:0];
  assign is_shift = (e_i_funct3 == 3'b001) || (e_i_funct3 == 3'b101);
  // Shift-immediates carry the SRAI selector in bit 30 and a 5-bit shamt.
  assign shamt_f  = {1'b0, e_i_alt, 5'b0, e_i_imm[4:0]};

  // Pack the field set according to its op class; unknown classes are flagged illegal.
  always_comb begin
    word     = 32'h0;
    legal_op = 1'b1;
    case (e_i_op)
      OP_RTYPE:  word = {1'b0, e_i_alt, 5'b0, rs2_f, rs1_f, e_i_funct3, rd_f, `OPCODE_OP};
      OP_ITYPE:  word = {(is_shift ? shamt_f : e_i_imm[11:0]), rs1_f, e_i_funct3, rd_f, `OPCODE_OP_IMM};
      OP_LOAD:   word = {e_i_imm[11:0], rs1_f, e_i_funct3, rd_f, `OPCODE_LOAD};
      OP_STORE:  word = {e_i_imm[11:5], rs2_f, rs1_f, e_i_funct3, e_i_imm[4:0], `OPCODE_STORE};
      OP_BRANCH: word = {e_i_imm[12], e_i_imm[10:5], rs2_f, rs1_f, e_i_funct3,
                         e_i_imm[4:1], e_i_imm[11], `OPCODE_BRANCH};
      OP_JAL:    word = {e_i_imm[20], e_i_imm[10:1], e_i_imm[11], e_i_imm[19:12], rd_f, `OPCODE_JAL};
      OP_JALR:   word = {e_i_imm[11:0], rs1_f, e_i_funct3, rd_f, `OPCODE_JALR};
      OP_LUI:    word = {e_i_imm[31:12], rd_f, `OPCODE_LUI};
      OP_AUIPC:  word = {e_i_imm[31:12], rd_f, `OPCODE_AUIPC};
      OP_SYSTEM: word = {e_i_imm[11:0], rs1_f, e_i_funct3, rd_f, `OPCODE_SYSTEM};
      OP_FENCE:  word = {e_i_imm[11:0], rs1_f, e_i_funct3, rd_f, `OPCODE_FENCE};
      default:   legal_op = 1'b0;
    endcase
  end

`ifdef ENCODER_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               fits12;
  assign simm   = $signed(e_i_imm);
  assign fits12 = (simm >= -32'sd2048) && (simm <= 32'sd2047);

  // Reject immediates that the encoded field cannot represent exactly.
  always_comb begin
    range_ok = 1'b1;
    case (e_i_op)
      OP_ITYPE:            range_ok = is_shift ? (e_i_imm[31:5] == 27'h0) : fits12;
      OP_LOAD, OP_STORE,
      OP_JALR:             range_ok = fits12;
      OP_SYSTEM, OP_FENCE: range_ok = (e_i_imm <= 32'd4095);
      OP_BRANCH:           range_ok = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !e_i_imm[0];
      OP_JAL:              range_ok = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !e_i_imm[0];
      OP_LUI, OP_AUIPC:    range_ok = (e_i_imm[11:0] == 12'h0);
      default:             range_ok = 1'b1;
    endcase
  end
`else
  assign range_ok = 1'b1;
`endif

  assign e_o_valid = (count != '0);
  assign e_o_ready = (count != CNT_W'(DEPTH));
  assign accept    = e_i_valid && e_o_ready;
  assign push      = accept && legal_op && range_ok;
  assign reject    = accept && !(legal_op && range_ok);
  assign pop       = e_o_valid && e_i_ready;

  assign e_o_instr = mem_instr[rd_ptr];
  assign e_o_pc    = mem_pc[rd_ptr];
  assign e_o_err   = err;

  // Pointers, occupancy, PC tag and sticky error; flush overrides push and pop.
  always_ff @(posedge e_clk) begin
    if (!e_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_tag <= RESET_PC;
      err    <= 1'b0;
    end else if (e_i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      pc_tag <= RESET_PC;
      err    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        pc_tag <= pc_tag + PC_WIDTH'(4);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (reject) begin
        err <= 1'b1;
      end
    end
  end

  // Storage write; cleared on reset so the empty head reads instr=0, pc=RESET_PC.
  always_ff @(posedge e_clk) begin
    if (!e_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_instr[i] <= 32'h0;
        mem_pc[i]    <= RESET_PC;
      end
    end else if (push && !e_i_flush) begin
      mem_instr[wr_ptr] <= word;
      mem_pc[wr_ptr]    <= pc_tag;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder; expected words queued at drive time, checked at pop.
// Inputs change on the falling edge; outputs are sampled 3 time units after the falling edge.
// Range-check expectations follow ENCODER_RANGE_CHECK_EN when it is defined for the build.

module tb_instr_encoder;

  logic        e_clk = 1'b0;
  logic        e_rst;
  logic        e_i_valid;
  logic        e_o_ready;
  logic [3:0]  e_i_op;
  logic [2:0]  e_i_funct3;
  logic        e_i_alt;
  logic [4:0]  e_i_rs1, e_i_rs2, e_i_rd;
  logic [31:0] e_i_imm;
  logic        e_i_flush;
  logic        e_o_valid;
  logic        e_i_ready;
  logic [31:0] e_o_instr;
  logic [31:0] e_o_pc;
  logic        e_o_err;

  always #5 e_clk = ~e_clk;

  instr_encoder #(.DEPTH(4), .PC_WIDTH(32), .AWIDTH(5), .RESET_PC(32'h0)) dut (
    .e_clk(e_clk), .e_rst(e_rst), .e_i_valid(e_i_valid), .e_o_ready(e_o_ready),
    .e_i_op(e_i_op), .e_i_funct3(e_i_funct3), .e_i_alt(e_i_alt),
    .e_i_rs1(e_i_rs1), .e_i_rs2(e_i_rs2), .e_i_rd(e_i_rd), .e_i_imm(e_i_imm),
    .e_i_flush(e_i_flush), .e_o_valid(e_o_valid), .e_i_ready(e_i_ready),
    .e_o_instr(e_o_instr), .e_o_pc(e_o_pc), .e_o_err(e_o_err)
  );

`ifdef ENCODER_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] exp_pc;
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference encoding built field by field into a word.
  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'h0;
    w[11:7]  = rd;
    w[14:12] = f3;
    w[19:15] = rs1;
    w[24:20] = rs2;
    case (op)
      4'd0: begin w[6:0] = 7'h33; w[30] = alt; end
      4'd1: begin
        w[6:0] = 7'h13;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          w[31:20] = 12'h0; w[24:20] = imm[4:0]; w[30] = alt;
        end else w[31:20] = imm[11:0];
      end
      4'd2: begin w[6:0] = 7'h03; w[31:20] = imm[11:0]; end
      4'd3: begin w[6:0] = 7'h23; w[11:7] = imm[4:0]; w[31:25] = imm[11:5]; end
      4'd4: begin w[6:0] = 7'h63; w[11:7] = {imm[4:1], imm[11]}; w[31:25] = {imm[12], imm[10:5]}; end
      4'd5: begin w[6:0] = 7'h6F; w[31:12] = {imm[20], imm[10:1], imm[11], imm[19:12]}; end
      4'd6: begin w[6:0] = 7'h67; w[31:20] = imm[11:0]; end
      4'd7: begin w[6:0] = 7'h37; w[31:12] = imm[31:12]; end
      4'd8: begin w[6:0] = 7'h17; w[31:12] = imm[31:12]; end
      4'd9: begin w[6:0] = 7'h73; w[31:20] = imm[11:0]; end
      4'd10: begin w[6:0] = 7'h0F; w[31:20] = imm[11:0]; end
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic legal(input logic [3:0] op, input logic [2:0] f3, input logic [31:0] imm);
    int  s;
    logic rok;
    s   = int'(imm);
    rok = 1'b1;
    case (op)
      4'd1: rok = (f3 == 3'd1 || f3 == 3'd5) ? (imm < 32) : (s >= -2048 && s <= 2047);
      4'd2, 4'd3, 4'd6: rok = (s >= -2048 && s <= 2047);
      4'd9, 4'd10: rok = (imm < 4096);
      4'd4: rok = (s >= -4096 && s <= 4094 && (s % 2 == 0));
      4'd5: rok = (s >= -1048576 && s <= 1048574 && (s % 2 == 0));
      4'd7, 4'd8: rok = (imm % 4096 == 0);
      default: rok = 1'b1;
    endcase
    return (op <= 4'd10) && (!RANGE_EN || rok);
  endfunction

  // One-cycle field-set drive; called right after a falling edge.
  task automatic drive(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic [31:0] imm);
    e_i_valid = 1'b1; e_i_op = op; e_i_funct3 = f3; e_i_alt = alt;
    e_i_rs1 = rs1; e_i_rs2 = rs2; e_i_rd = rd; e_i_imm = imm;
    @(negedge e_clk);
    e_i_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!e_o_ready && n < 64) begin
      @(negedge e_clk);
      n++;
    end
    if (!e_o_ready) chk("ready_timeout", 32'(e_o_ready), 32'd1);
  endtask

  // Send with an explicit expected word (legal set).
  task automatic send(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic [31:0] imm, input logic [31:0] word);
    wait_ready();
    sbq.push_back({word, exp_pc});
    exp_pc += 32'd4;
    drive(op, f3, alt, rs1, rs2, rd, imm);
  endtask

  // Send with expectation from the reference model.
  task automatic send_m(input logic [3:0] op, input logic [2:0] f3, input logic alt,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [31:0] imm);
    wait_ready();
    if (legal(op, f3, imm)) begin
      sbq.push_back({enc(op, f3, alt, rs1, rs2, rd, imm), exp_pc});
      exp_pc += 32'd4;
    end
    drive(op, f3, alt, rs1, rs2, rd, imm);
  endtask

  task automatic drain();
    e_i_ready = 1'b1;
    repeat (8) @(negedge e_clk);
    chk("drain_valid", 32'(e_o_valid), 32'd0);
    chk("drain_sb_left", 32'(sbq.size()), 32'd0);
  endtask

  // Scoreboard: compare the head against the oldest expectation whenever it is popped.
  initial begin
    exp_t e;
    forever begin
      @(negedge e_clk);
      #3;
      if (e_rst && !e_i_flush && e_o_valid && e_i_ready) begin
        if (sbq.size() == 0) chk("sb_occupancy", 32'(sbq.size()), 32'd1);
        else begin
          e = sbq.pop_front();
          chk("head_instr", e_o_instr, e.instr);
          chk("head_pc", e_o_pc, e.pc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int v;
    logic [2:0] f3;
    e_rst = 1'b0; e_i_valid = 1'b0; e_i_op = '0; e_i_funct3 = '0; e_i_alt = 1'b0;
    e_i_rs1 = '0; e_i_rs2 = '0; e_i_rd = '0; e_i_imm = '0; e_i_flush = 1'b0; e_i_ready = 1'b0;
    exp_pc = 32'h0;
    repeat (3) @(negedge e_clk);
    chk("rst_valid", 32'(e_o_valid), 32'd0);
    chk("rst_ready", 32'(e_o_ready), 32'd1);
    chk("rst_instr", e_o_instr, 32'h0);
    chk("rst_pc", e_o_pc, 32'h0);
    chk("rst_err", 32'(e_o_err), 32'd0);
    e_rst = 1'b1;
    @(negedge e_clk);

    // addi x1,x0,5: visible one cycle after the accept edge
    send(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5, 32'h00500093);
    chk("t1_valid", 32'(e_o_valid), 32'd1);
    chk("t1_instr", e_o_instr, 32'h00500093);
    chk("t1_pc", e_o_pc, 32'h0);
    e_i_ready = 1'b1;
    @(negedge e_clk);

    // add / sub, then branch, jal, lui, srai
    send(4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
    send(4'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0, 32'h402081B3);
    send(4'd4, 3'd0, 1'b0, 5'd1, 5'd2, 5'd0, 32'd8, 32'h00208463);
    send(4'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h001000EF);
    send(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'd5, 32'h12345000, 32'h123452B7);
    send(4'd1, 3'd5, 1'b1, 5'd1, 5'd0, 5'd1, 32'd3, 32'h4030D093);
    drain();

    // Fill to full with no pops, offer a 5th set, then push+pop while full
    e_i_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_m(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'(i + 1), 32'(10 + i));
    chk("full_ready", 32'(e_o_ready), 32'd0);
    drive(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd9, 32'd99);
    chk("full_ready_hold", 32'(e_o_ready), 32'd0);
    e_i_ready = 1'b1;
    drive(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd10, 32'd77);
    chk("pushpop_ready", 32'(e_o_ready), 32'd1);
    drain();

    // Illegal op: sticky error, tag held; then an addi whose imm exceeds 12 bits
    drive(4'd12, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    chk("illegal_err", 32'(e_o_err), 32'd1);
    chk("illegal_valid", 32'(e_o_valid), 32'd0);
    send_m(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd2, 32'd7);
    send_m(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd4096);
    @(negedge e_clk);
    chk("err_sticky", 32'(e_o_err), 32'd1);
    drain();

    // Flush with 3 queued words and a simultaneous valid set
    e_i_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_m(4'd0, 3'(i), 1'b0, 5'd4, 5'd5, 5'd6, 32'd0);
    e_i_flush = 1'b1;
    drive(4'd0, 3'd0, 1'b0, 5'd1, 5'd1, 5'd1, 32'd0);
    e_i_flush = 1'b0;
    sbq.delete();
    exp_pc = 32'h0;
    chk("flush_valid", 32'(e_o_valid), 32'd0);
    chk("flush_err", 32'(e_o_err), 32'd0);
    chk("flush_ready", 32'(e_o_ready), 32'd1);
    e_i_ready = 1'b1;
    send_m(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
    drain();

    // Mixed traffic with random downstream stalls
    for (int n = 0; n < 30; n++) begin
      e_i_ready = e_o_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 4))
        0: send_m(4'd0, f3, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom), 32'd0);
        1: begin
          if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
          v = int'($urandom_range(0, 4095)) - 2048;
          send_m(4'd1, f3, 1'b0, 5'($urandom), 5'd0, 5'($urandom), 32'(v));
        end
        2: begin
          v = int'($urandom_range(0, 4095)) - 2048;
          send_m(4'd3, f3, 1'b0, 5'($urandom), 5'($urandom), 5'd0, 32'(v));
        end
        3: send_m(4'd7, 3'd0, 1'b0, 5'd0, 5'd0, 5'($urandom), {20'($urandom), 12'h0});
        default: begin
          v = (int'($urandom_range(0, 4095)) - 2048) * 2;
          send_m(4'd4, f3, 1'b0, 5'($urandom), 5'($urandom), 5'd0, 32'(v));
        end
      endcase
    end
    drain();

    // Reset mid-transfer drops all buffered words
    e_i_ready = 1'b0;
    send_m(4'd0, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd0);
    send_m(4'd0, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 32'd0);
    e_rst = 1'b0;
    @(negedge e_clk);
    sbq.delete();
    exp_pc = 32'h0;
    chk("rst2_valid", 32'(e_o_valid), 32'd0);
    chk("rst2_instr", e_o_instr, 32'h0);
    chk("rst2_pc", e_o_pc, 32'h0);
    e_rst = 1'b1;
    @(negedge e_clk);
    send_m(4'd1, 3'd0, 1'b0, 5'd0, 5'd0, 5'd1, 32'd5);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
